match_scan: RTL and testbench

- Sequential, parametrised successor to the combinational single-shot first-match priority encoder used after parallel CAM/tag search.
- Captures a search-valid vector and streams out every matched index, one per accepted handshake, in priority order.
- Reports the match count and a completion or miss indication.
- Sits between the parallel search array and any consumer that must visit all hits, such as invalidate-all or multi-hit resolution.

---
 rtl/match_scan.sv | 126 ++++++++++++
 tb/tb_match_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/match_scan.sv
// match_scan: captures a search-valid vector and streams every matched index
// out over a valid/ready handshake in priority order. It also reports the
// match count and a one-cycle done/miss indication at the end of the scan.
module match_scan #(
   parameter int DEPTH     = 32,
   parameter int WIDTH     = $clog2(DEPTH) + 1,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [DEPTH-1:0] search_valid_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             index_valid_o,
   input  logic             index_ready_i,
   output logic [WIDTH-1:0] index_o,
   output logic             last_o,
   output logic [WIDTH-1:0] match_count_o,
   output logic             done_o,
   output logic             miss_o
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             miss_q, miss_d;

   logic [WIDTH-1:0] pick_idx;
   logic             one_left;
   logic             xfer;

   // Highest-priority set bit; returns DEPTH when nothing is pending.
   function automatic logic [WIDTH-1:0] prio_pick(input logic [DEPTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = WIDTH'(DEPTH);
      if (MSB_FIRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (v[i]) r = WIDTH'(i);
         end
      end else begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) r = WIDTH'(i);
         end
      end
      return r;
   endfunction

   // Number of set bits; WIDTH holds DEPTH so an all-ones vector fits.
   function automatic logic [WIDTH-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         c = c + WIDTH'(v[i]);
      end
      return c;
   endfunction

   // Decode the pending vector into the presented index and handshake outputs.
   always_comb begin
      pick_idx      = prio_pick(pending_q);
      one_left      = (pending_q != '0) &&
                      ((pending_q & (pending_q - DEPTH'(1))) == '0);
      busy_o        = (state_q != S_IDLE);
      index_valid_o = (state_q == S_SCAN);
      index_o       = (state_q == S_SCAN) ? pick_idx : WIDTH'(DEPTH);
      last_o        = (state_q == S_SCAN) && one_left;
      done_o        = (state_q == S_DONE);
      miss_o        = (state_q == S_DONE) && miss_q;
      match_count_o = count_q;
      xfer          = (state_q == S_SCAN) && index_ready_i;
   end

   // Next-state logic: capture in IDLE, retire one bit per transfer in SCAN.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      miss_d    = miss_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pending_d = search_valid_i;
               count_d   = popcount(search_valid_i);
               miss_d    = (search_valid_i == '0);
               state_d   = (search_valid_i != '0) ? S_SCAN : S_DONE;
            end
         end
         S_SCAN: begin
            if (abort_i) begin
               // An accompanying transfer is simply dropped with the rest.
               pending_d = '0;
               state_d   = S_IDLE;
            end else if (xfer) begin
               pending_d = pending_q & ~(DEPTH'(1) << pick_idx);
               if (one_left) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            pending_d = '0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // State and captured-data registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         count_q   <= '0;
         miss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         miss_q    <= miss_d;
      end
   end

endmodule

// File: tb/tb_match_scan.sv
// Directed bench for match_scan: one LSB-first and one MSB-first instance
// driven by the same inputs, with hand-computed expected outputs.
module tb_match_scan;

   localparam int DEPTH = 32;
   localparam int WIDTH = 6;

   logic             clk = 1'b0;
   logic             rst, start, abort, ready;
   logic [DEPTH-1:0] sv;

   logic             a_busy, a_vld, a_last, a_done, a_miss;
   logic [WIDTH-1:0] a_idx, a_cnt;
   logic             b_busy, b_vld, b_last, b_done, b_miss;
   logic [WIDTH-1:0] b_idx, b_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int a_xfers = 0, a_dones = 0, b_xfers = 0, b_dones = 0;
   int base_x, base_d;

   always #5 clk = ~clk;

   match_scan #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk), .rst_i(rst), .start_i(start), .search_valid_i(sv),
      .abort_i(abort), .busy_o(a_busy), .index_valid_o(a_vld),
      .index_ready_i(ready), .index_o(a_idx), .last_o(a_last),
      .match_count_o(a_cnt), .done_o(a_done), .miss_o(a_miss)
   );

   match_scan #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
      .clk_i(clk), .rst_i(rst), .start_i(start), .search_valid_i(sv),
      .abort_i(abort), .busy_o(b_busy), .index_valid_o(b_vld),
      .index_ready_i(ready), .index_o(b_idx), .last_o(b_last),
      .match_count_o(b_cnt), .done_o(b_done), .miss_o(b_miss)
   );

   // Count handshakes and done pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (a_vld && ready) a_xfers++;
      if (b_vld && ready) b_xfers++;
      if (a_done) a_dones++;
      if (b_done) b_dones++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, ".busy"}, 32'(a_busy), 32'd0);
      chk({tag, ".vld"},  32'(a_vld),  32'd0);
      chk({tag, ".idx"},  32'(a_idx),  32'd32);
      chk({tag, ".last"}, 32'(a_last), 32'd0);
      chk({tag, ".done"}, 32'(a_done), 32'd0);
      chk({tag, ".miss"}, 32'(a_miss), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; sv = '0;
      #1;
      step(); step();
      rst = 1'b0;
      chk_idle_a("rst");
      chk("rst.cnt", 32'(a_cnt), 32'd0);
      chk("rst.b_idx", 32'(b_idx), 32'd32);

      // Three hits, ready held high.
      sv = 32'h8000_0011; ready = 1'b1; start = 1'b1;
      base_x = a_xfers; base_d = a_dones;
      step(); start = 1'b0;
      chk("t1.cnt",  32'(a_cnt),  32'd3);
      chk("t1.vld0", 32'(a_vld),  32'd1);
      chk("t1.idx0", 32'(a_idx),  32'd0);
      chk("t1.last0", 32'(a_last), 32'd0);
      step();
      chk("t1.idx1", 32'(a_idx),  32'd4);
      chk("t1.last1", 32'(a_last), 32'd0);
      step();
      chk("t1.idx2", 32'(a_idx),  32'd31);
      chk("t1.last2", 32'(a_last), 32'd1);
      step();
      chk("t1.done", 32'(a_done), 32'd1);
      chk("t1.miss", 32'(a_miss), 32'd0);
      chk("t1.vldD", 32'(a_vld),  32'd0);
      chk("t1.idxD", 32'(a_idx),  32'd32);
      step();
      chk_idle_a("t1.end");
      chk("t1.xfers", 32'(a_xfers - base_x), 32'd3);
      chk("t1.dones", 32'(a_dones - base_d), 32'd1);

      // Empty vector: miss.
      sv = '0; start = 1'b1;
      step(); start = 1'b0;
      chk("t2.cnt",  32'(a_cnt),  32'd0);
      chk("t2.vld",  32'(a_vld),  32'd0);
      chk("t2.done", 32'(a_done), 32'd1);
      chk("t2.miss", 32'(a_miss), 32'd1);
      chk("t2.busy", 32'(a_busy), 32'd1);
      step();
      chk_idle_a("t2.end");

      // Stall with ready low for three cycles.
      sv = 32'h0000_0006; ready = 1'b0; start = 1'b1;
      base_x = a_xfers;
      step(); start = 1'b0;
      sv = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         chk("t3.stall_idx",  32'(a_idx),  32'd1);
         chk("t3.stall_vld",  32'(a_vld),  32'd1);
         chk("t3.stall_last", 32'(a_last), 32'd0);
         if (i < 2) step();
      end
      ready = 1'b1;
      step();
      chk("t3.idx2",  32'(a_idx),  32'd2);
      chk("t3.last2", 32'(a_last), 32'd1);
      step();
      chk("t3.done", 32'(a_done), 32'd1);
      chk("t3.xfers", 32'(a_xfers - base_x), 32'd2);
      step();

      // All ones on the MSB-first instance.
      sv = 32'hFFFF_FFFF; ready = 1'b1; start = 1'b1;
      base_x = b_xfers; base_d = b_dones;
      step(); start = 1'b0;
      chk("t4.cnt", 32'(b_cnt), 32'd32);
      chk("t4.a_cnt", 32'(a_cnt), 32'd32);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t4.idx",  32'(b_idx),  32'(31 - i));
         chk("t4.last", 32'(b_last), (i == DEPTH - 1) ? 32'd1 : 32'd0);
         step();
      end
      chk("t4.done", 32'(b_done), 32'd1);
      chk("t4.miss", 32'(b_miss), 32'd0);
      step();
      chk("t4.busy", 32'(b_busy), 32'd0);
      chk("t4.xfers", 32'(b_xfers - base_x), 32'd32);
      chk("t4.dones", 32'(b_dones - base_d), 32'd1);

      // Abort with a coincident transfer.
      sv = 32'h0000_00F0; ready = 1'b1; start = 1'b1;
      base_d = a_dones;
      step(); start = 1'b0;
      chk("t5.idx4", 32'(a_idx), 32'd4);
      step();
      chk("t5.idx5", 32'(a_idx), 32'd5);
      abort = 1'b1;
      step(); abort = 1'b0;
      chk_idle_a("t5.abort");
      chk("t5.dones", 32'(a_dones - base_d), 32'd0);
      sv = 32'h8000_0000; start = 1'b1;
      step(); start = 1'b0;
      chk("t5.restart_vld",  32'(a_vld),  32'd1);
      chk("t5.restart_idx",  32'(a_idx),  32'd31);
      chk("t5.restart_cnt",  32'(a_cnt),  32'd1);
      chk("t5.restart_last", 32'(a_last), 32'd1);
      step();
      chk("t5.done", 32'(a_done), 32'd1);
      step();

      // Start ignored during SCAN, then reset mid-scan.
      sv = 32'h0F0F_0000; ready = 1'b1; start = 1'b1;
      step();
      chk("t6.cnt",  32'(a_cnt), 32'd8);
      chk("t6.idx",  32'(a_idx), 32'd16);
      sv = 32'hFFFF_FFFF;
      step(); start = 1'b0;
      chk("t6.cnt_held", 32'(a_cnt), 32'd8);
      chk("t6.idx17",    32'(a_idx), 32'd17);
      rst = 1'b1;
      step(); rst = 1'b0;
      chk_idle_a("t6.rst");
      chk("t6.rst_cnt", 32'(a_cnt), 32'd0);

      // Start ignored in DONE.
      sv = 32'h0000_0001; ready = 1'b1; start = 1'b1;
      step();
      chk("t6.bit0_idx", 32'(a_idx), 32'd0);
      sv = '0;
      step();
      chk("t6.done_b0", 32'(a_done), 32'd1);
      sv = 32'h0000_0003;
      step(); start = 1'b0;
      chk("t6.ign_busy", 32'(a_busy), 32'd0);
      chk("t6.ign_cnt",  32'(a_cnt),  32'd1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
